// File: rtl/split_bus_pkg.sv
// split_bus_pkg: shared split-bus state encoding and bus constants
package split_bus_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;
  typedef enum logic [2:0] {IDLE, WACK, RRESP, SPLIT, RESUME} state_t;
endpackage

// File: rtl/split_slave_mem.sv
// split_slave_mem: single-port write-first RAM with one-cycle registered read
module split_slave_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // rdata only moves on an access, so it doubles as the accept-time snapshot
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= we ? wdata : mem[addr];
    end
  end
endmodule

// File: rtl/split_slave.sv
// split_slave: split-capable bus responder with local memory
module split_slave #(
  parameter int ADDR_W    = split_bus_pkg::DEF_ADDR_W,
  parameter int DATA_W    = split_bus_pkg::DEF_DATA_W,
  parameter int SPLIT_LAT = 4,
  parameter int GRANT_TO  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ssel,
  input  logic              mvalid,
  input  logic              mwrite,
  input  logic [ADDR_W-1:0] maddr,
  input  logic [DATA_W-1:0] mwdata,
  input  logic              split_grant,
  output logic              sready,
  output logic              ssplit,
  output logic              srvalid,
  output logic [DATA_W-1:0] srdata,
  output logic              serr
);
  import split_bus_pkg::*;
  localparam int CMAX = SPLIT_LAT > GRANT_TO ? SPLIT_LAT : GRANT_TO;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAT_INIT = SPLIT_LAT > 0 ? CW'(SPLIT_LAT - 1) : '0;
  localparam logic [CW-1:0] TO_LAST = CW'(GRANT_TO - 1);
  localparam logic [CW-1:0] TO_END = CW'(GRANT_TO);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic serr_q, serr_d;
  logic [DATA_W-1:0] srdata_q, rdata;
  logic accept;

  assign accept  = ssel & mvalid & (state_q == IDLE);
  assign sready  = state_q == IDLE;
  assign ssplit  = state_q == SPLIT;
  assign srvalid = (state_q == WACK) | (state_q == RRESP);
  assign serr    = serr_q;
  assign srdata  = state_q == RRESP ? rdata : srdata_q;

  split_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .en    (accept & rstn),
    .we    (mwrite),
    .addr  (maddr),
    .wdata (mwdata),
    .rdata (rdata)
  );

  // next state, split/grant counter and error pulse; any request while busy is rejected
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    serr_d = ssel & mvalid & (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = mwrite ? WACK : (SPLIT_LAT == 0 ? RRESP : SPLIT);
          cnt_d = LAT_INIT;
        end
      end
      WACK, RRESP: state_d = IDLE;
      SPLIT: begin
        if (cnt_q == '0) state_d = RESUME;
        else cnt_d = cnt_q - CW'(1);
      end
      RESUME: begin
        if (cnt_q == TO_END) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (split_grant) begin
          state_d = RRESP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          serr_d = serr_d | (cnt_q == TO_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter, error pulse and last returned word
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      serr_q <= 1'b0;
      srdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      serr_q <= serr_d;
      srdata_q <= srdata;
    end
  end
endmodule

// File: tb/tb_split_slave.sv
// tb_split_slave: directed checks of unsplit and split slave behaviour
module tb_split_slave;
  typedef struct packed {
    logic sel, mv, wr;
    logic [7:0] a, d;
    logic rdy, vld, err;
    logic [7:0] rd;
  } vec_t;

  logic clk = 0, rstn = 0;
  logic sel0, sel4, mvalid, mwrite, grant;
  logic [7:0] maddr, mwdata;
  logic rdy0, spl0, vld0, err0, rdy4, spl4, vld4, err4;
  logic [7:0] rd0, rd4;
  int checks = 0, errors = 0;
  vec_t tv [16];

  always #5 clk = ~clk;

  split_slave #(.ADDR_W(8), .DATA_W(8), .SPLIT_LAT(0), .GRANT_TO(16)) u0 (
    .clk(clk), .rstn(rstn), .ssel(sel0), .mvalid(mvalid), .mwrite(mwrite),
    .maddr(maddr), .mwdata(mwdata), .split_grant(grant), .sready(rdy0),
    .ssplit(spl0), .srvalid(vld0), .srdata(rd0), .serr(err0));

  split_slave #(.ADDR_W(8), .DATA_W(8), .SPLIT_LAT(4), .GRANT_TO(16)) u4 (
    .clk(clk), .rstn(rstn), .ssel(sel4), .mvalid(mvalid), .mwrite(mwrite),
    .maddr(maddr), .mwdata(mwdata), .split_grant(grant), .sready(rdy4),
    .ssplit(spl4), .srvalid(vld4), .srdata(rd4), .serr(err4));

  function automatic vec_t mk(input logic s, m, w, input logic [7:0] a, d,
                              input logic r, v, e, input logic [7:0] rd);
    mk = {s, m, w, a, d, r, v, e, rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    sel0 = 0; sel4 = 0; mvalid = 0; mwrite = 0; maddr = 0; mwdata = 0; grant = 0;
  endtask

  task automatic req4(input logic w, input logic [7:0] a, d);
    sel4 = 1; mvalid = 1; mwrite = w; maddr = a; mwdata = d;
  endtask

  task automatic split_read(input logic [7:0] a, exp);
    req4(0, a, 0);
    step();
    idle_in();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ssplit_hold_%0d", i), spl4, 1);
      chk($sformatf("sready_split_%0d", i), rdy4, 0);
      step();
    end
    chk("ssplit_drop", spl4, 0);
    chk("sready_resume", rdy4, 0);
    step();
    step();
    grant = 1;
    step();
    grant = 0;
    chk("split_srvalid", vld4, 1);
    chk("split_srdata", rd4, exp);
    step();
    chk("split_sready_back", rdy4, 1);
    chk("split_srvalid_drop", vld4, 0);
  endtask

  initial begin
    tv[0]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00);
    tv[1]  = mk(1, 1, 1, 8'h10, 8'h5A, 0, 1, 0, 8'h00);
    tv[2]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00);
    tv[3]  = mk(1, 1, 0, 8'h10, 8'h00, 0, 1, 0, 8'h5A);
    tv[4]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h5A);
    tv[5]  = mk(1, 1, 1, 8'h20, 8'hC3, 0, 1, 0, 8'h5A);
    tv[6]  = mk(1, 1, 1, 8'h20, 8'h00, 1, 0, 1, 8'h5A);
    tv[7]  = mk(1, 1, 0, 8'h20, 8'h00, 0, 1, 0, 8'hC3);
    tv[8]  = mk(1, 1, 0, 8'h20, 8'h00, 1, 0, 1, 8'hC3);
    tv[9]  = mk(0, 1, 1, 8'h20, 8'h99, 1, 0, 0, 8'hC3);
    tv[10] = mk(1, 0, 1, 8'h20, 8'h99, 1, 0, 0, 8'hC3);
    tv[11] = mk(1, 1, 1, 8'hFF, 8'hA5, 0, 1, 0, 8'hC3);
    tv[12] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hC3);
    tv[13] = mk(1, 1, 0, 8'hFF, 8'h00, 0, 1, 0, 8'hA5);
    tv[14] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5);
    tv[15] = mk(1, 1, 0, 8'h20, 8'h00, 0, 1, 0, 8'hC3);

    idle_in();
    rstn = 0;
    step();
    step();
    rstn = 1;
    chk("rst_sready", rdy4, 1);
    chk("rst_ssplit", spl4, 0);
    chk("rst_srvalid", vld4, 0);
    chk("rst_srdata", rd4, 8'h00);
    chk("rst_serr", err4, 0);
    chk("rst_sready_u0", rdy0, 1);
    chk("rst_srdata_u0", rd0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      sel0 = tv[i].sel; mvalid = tv[i].mv; mwrite = tv[i].wr;
      maddr = tv[i].a; mwdata = tv[i].d;
      step();
      idle_in();
      chk($sformatf("tv%0d_sready", i), rdy0, tv[i].rdy);
      chk($sformatf("tv%0d_srvalid", i), vld0, tv[i].vld);
      chk($sformatf("tv%0d_serr", i), err0, tv[i].err);
      chk($sformatf("tv%0d_srdata", i), rd0, tv[i].rd);
      chk($sformatf("tv%0d_ssplit", i), spl0, 0);
    end

    grant = 1;
    step();
    grant = 0;
    chk("stray_grant_srvalid", vld4, 0);
    chk("stray_grant_sready", rdy4, 1);

    req4(1, 8'h10, 8'h5A);
    step();
    idle_in();
    chk("u4_write_ack", vld4, 1);
    step();
    split_read(8'h10, 8'h5A);

    req4(0, 8'h10, 0);
    step();
    req4(1, 8'h10, 8'hFF);
    step();
    idle_in();
    chk("busy_serr", err4, 1);
    chk("busy_ssplit", spl4, 1);
    step();
    chk("busy_serr_drop", err4, 0);
    chk("busy_ssplit_still", spl4, 1);
    step();
    step();
    chk("busy_resume", spl4, 0);
    grant = 1;
    step();
    grant = 0;
    chk("busy_split_srvalid", vld4, 1);
    chk("busy_split_srdata", rd4, 8'h5A);
    step();
    split_read(8'h10, 8'h5A);

    req4(0, 8'h10, 0);
    step();
    idle_in();
    repeat (4) step();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_wait%0d_serr", i), err4, 0);
      chk($sformatf("to_wait%0d_srvalid", i), vld4, 0);
      chk($sformatf("to_wait%0d_sready", i), rdy4, 0);
      step();
    end
    chk("timeout_serr", err4, 1);
    chk("timeout_sready_low", rdy4, 0);
    chk("timeout_srvalid", vld4, 0);
    step();
    chk("timeout_sready", rdy4, 1);
    chk("timeout_serr_drop", err4, 0);
    chk("timeout_srvalid_after", vld4, 0);

    req4(0, 8'h10, 0);
    step();
    idle_in();
    repeat (4) step();
    repeat (15) step();
    grant = 1;
    step();
    grant = 0;
    chk("late_grant_srvalid", vld4, 1);
    chk("late_grant_serr", err4, 0);
    chk("late_grant_srdata", rd4, 8'h5A);
    step();

    req4(0, 8'h10, 0);
    step();
    idle_in();
    step();
    rstn = 0;
    step();
    rstn = 1;
    chk("midrst_ssplit", spl4, 0);
    chk("midrst_sready", rdy4, 1);
    chk("midrst_srvalid", vld4, 0);
    chk("midrst_srdata", rd4, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("midrst_quiet%0d", i), vld4, 0);
    end
    split_read(8'h10, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
